// File: rtl/prio_encoder_rr_pipe_if.sv
// prio_encoder_rr_pipe_if: request-in / index-out handshake bundle for the priority encoder stage
interface prio_encoder_rr_pipe_if #(
    parameter int WIDTH = 8
);
    localparam int POS_W = $clog2(WIDTH);
    logic [WIDTH-1:0] din;
    logic             din_valid;
    logic             din_ready;
    logic [POS_W-1:0] pos;
    logic             zero;
    logic             pos_valid;
    logic             pos_ready;
    modport master (
        output din, din_valid, pos_ready,
        input  din_ready, pos, zero, pos_valid
    );
    modport slave (
        input  din, din_valid, pos_ready,
        output din_ready, pos, zero, pos_valid
    );
endinterface

// File: rtl/prio_encoder_rr_pipe.sv
// prio_encoder_rr_pipe: one-deep registered priority encoder, fixed or round-robin, valid/ready on both sides
module prio_encoder_rr_pipe #(
    parameter int WIDTH = 8,
    parameter int RR    = 0
) (
    input logic clk,
    input logic reset,
    prio_encoder_rr_pipe_if.slave bus
);
    localparam int POS_W = $clog2(WIDTH);
    logic [POS_W-1:0] pos_q, pos_d, ptr_q, ptr_d, enc, lo, hi;
    logic             zero_q, zero_d, valid_q, valid_d, found_hi, ready, accept;
    assign ready         = !valid_q || bus.pos_ready;
    assign bus.din_ready = ready;
    assign bus.pos       = pos_q;
    assign bus.zero      = zero_q;
    assign bus.pos_valid = valid_q;
    always_comb begin
        lo       = '0;
        hi       = '0;
        found_hi = 1'b0;
        // descending scan: the last hit written is the lowest index, overall and at/after ptr
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (bus.din[i]) begin
                lo = POS_W'(i);
                if (i >= int'(ptr_q)) begin
                    hi       = POS_W'(i);
                    found_hi = 1'b1;
                end
            end
        end
        enc     = found_hi ? hi : lo;
        accept  = bus.din_valid && ready;
        valid_d = accept || (valid_q && !bus.pos_ready);
        pos_d   = accept ? enc : pos_q;
        zero_d  = accept ? (bus.din == '0) : zero_q;
        ptr_d   = (RR != 0 && accept && bus.din != '0)
                ? ((enc == POS_W'(WIDTH - 1)) ? '0 : enc + POS_W'(1))
                : ptr_q;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= 1'b0;
            pos_q   <= '0;
            zero_q  <= 1'b0;
            ptr_q   <= '0;
        end else begin
            valid_q <= valid_d;
            pos_q   <= pos_d;
            zero_q  <= zero_d;
            ptr_q   <= ptr_d;
        end
    end
endmodule

// File: tb/tb_prio_encoder_rr_pipe.sv
// tb_prio_encoder_rr_pipe: three encoder instances (fixed W8, rr W8, rr W5) against a rotating-search model
module tb_prio_encoder_rr_pipe;
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;
    int wd[3]  = '{8, 8, 5};
    int rrm[3] = '{0, 1, 1};
    int tgt[3] = '{256, 256, 32};
    logic [7:0] din[3];
    logic       dv[3], pr[3];
    logic [2:0] pos_o[3];
    logic       zero_o[3], pv_o[3], dr_o[3];
    int mv[3] = '{0, 0, 0}, mp[3] = '{0, 0, 0}, mz[3] = '{0, 0, 0}, mptr[3] = '{0, 0, 0};
    bit acc[3];
    bit armed = 1'b0;
    int checks = 0, errors = 0;
    prio_encoder_rr_pipe_if #(.WIDTH(8)) b0();
    prio_encoder_rr_pipe_if #(.WIDTH(8)) b1();
    prio_encoder_rr_pipe_if #(.WIDTH(5)) b2();
    prio_encoder_rr_pipe #(.WIDTH(8), .RR(0)) u0 (.clk(clk), .reset(reset), .bus(b0));
    prio_encoder_rr_pipe #(.WIDTH(8), .RR(1)) u1 (.clk(clk), .reset(reset), .bus(b1));
    prio_encoder_rr_pipe #(.WIDTH(5), .RR(1)) u2 (.clk(clk), .reset(reset), .bus(b2));
    assign b0.din = din[0];
    assign b1.din = din[1];
    assign b2.din = din[2][4:0];
    assign b0.din_valid = dv[0];
    assign b1.din_valid = dv[1];
    assign b2.din_valid = dv[2];
    assign b0.pos_ready = pr[0];
    assign b1.pos_ready = pr[1];
    assign b2.pos_ready = pr[2];
    assign pos_o[0] = b0.pos;
    assign pos_o[1] = b1.pos;
    assign pos_o[2] = b2.pos;
    assign zero_o[0] = b0.zero;
    assign zero_o[1] = b1.zero;
    assign zero_o[2] = b2.zero;
    assign pv_o[0] = b0.pos_valid;
    assign pv_o[1] = b1.pos_valid;
    assign pv_o[2] = b2.pos_valid;
    assign dr_o[0] = b0.din_ready;
    assign dr_o[1] = b1.din_ready;
    assign dr_o[2] = b2.din_ready;
    // search starts at p and rotates once around the vector
    function automatic int enc(int w, int d, int p);
        for (int k = 0; k < w; k++) begin
            int idx = (p + k) % w;
            if (d[idx]) return idx;
        end
        return 0;
    endfunction
    always @(posedge clk) begin
        for (int n = 0; n < 3; n++) begin
            if (reset) begin
                mv[n] = 0; mp[n] = 0; mz[n] = 0; mptr[n] = 0; acc[n] = 0;
            end else begin
                int d;
                d = int'(din[n]) & ((1 << wd[n]) - 1);
                acc[n] = dv[n] && (mv[n] == 0 || pr[n]);
                if (acc[n]) begin
                    mp[n] = enc(wd[n], d, mptr[n]);
                    mz[n] = (d == 0) ? 1 : 0;
                    mv[n] = 1;
                    if (rrm[n] != 0 && d != 0) mptr[n] = (mp[n] + 1) % wd[n];
                end else if (pr[n]) mv[n] = 0;
            end
        end
    end
    task automatic chk(string nm, int n, int got, int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s inst%0d got %0d want %0d at %0t", nm, n, got, want, $time);
        end
    endtask
    always @(negedge clk) begin
        if (armed) begin
            for (int n = 0; n < 3; n++) begin
                chk("model_valid", n, int'(pv_o[n]), mv[n]);
                chk("model_ready", n, int'(dr_o[n]), (mv[n] == 0 || pr[n]) ? 1 : 0);
                chk("model_pos", n, int'(pos_o[n]), mp[n]);
                chk("model_zero", n, int'(zero_o[n]), mz[n]);
            end
        end
    end
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic lit(int n, int p, int z);
        chk("lit_valid", n, int'(pv_o[n]), 1);
        chk("lit_pos", n, int'(pos_o[n]), p);
        chk("lit_zero", n, int'(zero_o[n]), z);
    endtask
    task automatic send(int n, int d, int p, int z);
        din[n] = 8'(d);
        dv[n] = 1'b1;
        pr[n] = 1'b1;
        tick();
        lit(n, p, z);
    endtask
    int e2[8] = '{4, 0, 1, 0, 2, 0, 1, 0};
    int ctr[3] = '{0, 0, 0};
    initial begin
        for (int n = 0; n < 3; n++) begin
            din[n] = 8'hFF; dv[n] = 1'b1; pr[n] = 1'b1;
        end
        tick();
        armed = 1'b1;
        tick();
        for (int n = 0; n < 3; n++) begin
            chk("rst_valid", n, int'(pv_o[n]), 0);
            chk("rst_pos", n, int'(pos_o[n]), 0);
            chk("rst_zero", n, int'(zero_o[n]), 0);
            chk("rst_ready", n, int'(dr_o[n]), 1);
            dv[n] = 1'b0;
        end
        reset = 1'b0;
        tick();
        for (int k = 0; k < 8; k++) send(0, 1 << k, k, 0);
        for (int k = 0; k < 8; k++) send(0, 8'h10 + k, e2[k], 0);
        send(0, 8'h00, 0, 1);
        send(0, 8'h80, 7, 0);
        dv[0] = 1'b0;
        for (int k = 0; k < 10; k++) send(1, 8'hFF, k % 8, 0);
        send(1, 8'h81, 7, 0);
        send(1, 8'h81, 0, 0);
        pr[1] = 1'b0;
        din[1] = 8'hFF;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("stall_ready", 1, int'(dr_o[1]), 0);
            lit(1, 0, 0);
        end
        pr[1] = 1'b1;
        tick();
        lit(1, 1, 0);
        dv[1] = 1'b0;
        tick();
        chk("drained", 1, int'(pv_o[1]), 0);
        send(2, 5'b10000, 4, 0);
        send(2, 5'b00001, 0, 0);
        send(2, 5'b00011, 1, 0);
        pr[2] = 1'b0;
        din[2] = 8'h04;
        tick();
        chk("stall_valid", 2, int'(pv_o[2]), 1);
        reset = 1'b1;
        tick();
        chk("rst_in_stall", 2, int'(pv_o[2]), 0);
        reset = 1'b0;
        dv[2] = 1'b0;
        pr[2] = 1'b1;
        tick();
        send(2, 5'b00011, 0, 0);
        dv[2] = 1'b0;
        for (int j = 0; j < 4000 && (ctr[0] < tgt[0] || ctr[1] < tgt[1] || ctr[2] < tgt[2]); j++) begin
            for (int n = 0; n < 3; n++) begin
                din[n] = (ctr[n] < tgt[n]) ? 8'(ctr[n]) : 8'($urandom);
                dv[n] = 1'($urandom);
                pr[n] = ($urandom % 4) != 0;
            end
            tick();
            for (int n = 0; n < 3; n++) if (acc[n]) ctr[n]++;
        end
        for (int n = 0; n < 3; n++) begin
            chk("sweep_done", n, (ctr[n] >= tgt[n]) ? 1 : 0, 1);
            dv[n] = 1'b0;
        end
        tick();
        tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
